// File: rtl/dual_ram_bist_if.sv
// Control and RAM-port bundle for the dual-port RAM BIST.
// slave = BIST side, master = host/RAM side.
interface dual_ram_bist_if #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [ADDR_WIDTH+1:0] err_count;
    logic [ADDR_WIDTH-1:0] fail_addr;
    logic                  fail_phase;
    logic                  ram_we1;
    logic                  ram_oe1;
    logic [ADDR_WIDTH-1:0] ram_addra;
    logic [DATA_WIDTH-1:0] ram_din_a;
    logic [DATA_WIDTH-1:0] ram_dout_a;
    logic                  ram_we2;
    logic                  ram_oe2;
    logic [ADDR_WIDTH-1:0] ram_addrb;
    logic [DATA_WIDTH-1:0] ram_din_b;
    logic [DATA_WIDTH-1:0] ram_dout_b;

    modport slave (
        input  start, ram_dout_a, ram_dout_b,
        output busy, done, pass, err_count, fail_addr, fail_phase,
               ram_we1, ram_oe1, ram_addra, ram_din_a,
               ram_we2, ram_oe2, ram_addrb, ram_din_b
    );

    modport master (
        output start, ram_dout_a, ram_dout_b,
        input  busy, done, pass, err_count, fail_addr, fail_phase,
               ram_we1, ram_oe1, ram_addra, ram_din_a,
               ram_we2, ram_oe2, ram_addrb, ram_din_b
    );
endinterface

// File: rtl/dual_ram_bist.sv
// Four-pass march BIST for a dual-port RAM: write A / read B, then write B / read A,
// with a two-stage compare pipeline matching the RAM's registered read data.
//
// state | meaning
// IDLE  | after reset, wait for start
// W0    | port A writes P0(a) over all addresses
// R0    | port B reads, expect P0(a)
// W1    | port B writes P1(a); port A parked on a^1
// R1    | port A reads, expect P1(a)
// DRAIN | two cycles for the last compares to land
// DONE  | results held, wait for start
module dual_ram_bist #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4
) (
    input logic            clk,
    input logic            rst,
    dual_ram_bist_if.slave bus
);
    localparam int ECW = ADDR_WIDTH + 2;
    localparam logic [ADDR_WIDTH-1:0] LAST = '1;

    typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DRAIN, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  start_ok;

    logic                  we1_q, we1_d, oe1_q, oe1_d, we2_q, we2_d, oe2_q, oe2_d;
    logic [ADDR_WIDTH-1:0] addra_q, addra_d, addrb_q, addrb_d;
    logic [DATA_WIDTH-1:0] dina_q, dina_d, dinb_q, dinb_d;

    logic                  v1_q, v1_d, v2_q, v2_d, ph1_q, ph1_d, ph2_q, ph2_d;
    logic [DATA_WIDTH-1:0] exp1_q, exp1_d, exp2_q, exp2_d;
    logic [ADDR_WIDTH-1:0] adr1_q, adr1_d, adr2_q, adr2_d;

    logic                  busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [ECW-1:0]        err_q, err_d;
    logic [ADDR_WIDTH-1:0] faddr_q, faddr_d;
    logic                  fph_q, fph_d;

    logic [DATA_WIDTH-1:0] p0, rd_data;
    logic                  mism;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we1_q   <= 1'b0;
            oe1_q   <= 1'b0;
            we2_q   <= 1'b0;
            oe2_q   <= 1'b0;
            addra_q <= '0;
            addrb_q <= '0;
            dina_q  <= '0;
            dinb_q  <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            ph1_q   <= 1'b0;
            ph2_q   <= 1'b0;
            exp1_q  <= '0;
            exp2_q  <= '0;
            adr1_q  <= '0;
            adr2_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            faddr_q <= '0;
            fph_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we1_q   <= we1_d;
            oe1_q   <= oe1_d;
            we2_q   <= we2_d;
            oe2_q   <= oe2_d;
            addra_q <= addra_d;
            addrb_q <= addrb_d;
            dina_q  <= dina_d;
            dinb_q  <= dinb_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            ph1_q   <= ph1_d;
            ph2_q   <= ph2_d;
            exp1_q  <= exp1_d;
            exp2_q  <= exp2_d;
            adr1_q  <= adr1_d;
            adr2_q  <= adr2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            faddr_q <= faddr_d;
            fph_q   <= fph_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        start_ok = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = W0;
                    cnt_d    = '0;
                    start_ok = 1'b1;
                end
            end
            W0, R0, W1, R1: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST) begin
                    case (state_q)
                        W0:      state_d = R0;
                        R0:      state_d = W1;
                        W1:      state_d = R1;
                        default: state_d = DRAIN;
                    endcase
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q[0]) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // RAM controls are decoded from the next state so they register in step with it.
    always_comb begin
        we1_d   = 1'b0;
        oe1_d   = 1'b0;
        we2_d   = 1'b0;
        oe2_d   = 1'b0;
        addra_d = '0;
        addrb_d = '0;
        dina_d  = '0;
        dinb_d  = '0;
        v1_d    = 1'b0;
        ph1_d   = 1'b0;
        exp1_d  = '0;
        adr1_d  = '0;
        p0      = cnt_d[DATA_WIDTH-1:0];
        case (state_d)
            W0: begin
                we1_d   = 1'b1;
                addra_d = cnt_d;
                dina_d  = p0;
            end
            R0: begin
                oe2_d   = 1'b1;
                addrb_d = cnt_d;
                v1_d    = 1'b1;
                exp1_d  = p0;
                adr1_d  = cnt_d;
            end
            W1: begin
                we2_d   = 1'b1;
                addrb_d = cnt_d;
                dinb_d  = ~p0;
                addra_d = cnt_d ^ ADDR_WIDTH'(1);
            end
            R1: begin
                oe1_d   = 1'b1;
                addra_d = cnt_d;
                v1_d    = 1'b1;
                ph1_d   = 1'b1;
                exp1_d  = ~p0;
                adr1_d  = cnt_d;
            end
            default: ;
        endcase
    end

    always_comb begin
        v2_d    = v1_q;
        ph2_d   = ph1_q;
        exp2_d  = exp1_q;
        adr2_d  = adr1_q;
        rd_data = ph2_q ? bus.ram_dout_a : bus.ram_dout_b;
        mism    = v2_q && (rd_data != exp2_q);
        err_d   = err_q;
        faddr_d = faddr_q;
        fph_d   = fph_q;
        if (start_ok) begin
            err_d   = '0;
            faddr_d = '0;
            fph_d   = 1'b0;
        end else if (mism) begin
            // err_count never wraps, so zero marks "no mismatch yet" this run.
            if (err_q == '0) begin
                faddr_d = adr2_q;
                fph_d   = ph2_q;
            end
            if (err_q != '1) err_d = err_q + ECW'(1);
        end
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
        pass_d = (state_d == DONE) && (err_d == '0);
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.fail_addr  = faddr_q;
    assign bus.fail_phase = fph_q;
    assign bus.ram_we1    = we1_q;
    assign bus.ram_oe1    = oe1_q;
    assign bus.ram_addra  = addra_q;
    assign bus.ram_din_a  = dina_q;
    assign bus.ram_we2    = we2_q;
    assign bus.ram_oe2    = oe2_q;
    assign bus.ram_addrb  = addrb_q;
    assign bus.ram_din_b  = dinb_q;
endmodule

// File: tb/tb_dual_ram_bist.sv
// Bench for dual_ram_bist: dual-port RAM model with per-address stuck-at masks,
// algorithm-level reference model, and a port-protocol monitor.
module tb_dual_ram_bist;
    localparam int DW    = 2;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int EMAX  = (1 << (AW + 2)) - 1;
    localparam int TLEN  = 4 * DEPTH + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dual_ram_bist_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dual_ram_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RAM with stuck-at read faults; port-B write is lost on an address collision
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] s1  [DEPTH];
    logic [DW-1:0] s0  [DEPTH];

    always @(posedge clk) begin
        if (bus.ram_we1) mem[bus.ram_addra] <= bus.ram_din_a;
        if (bus.ram_we2 && bus.ram_addra != bus.ram_addrb) mem[bus.ram_addrb] <= bus.ram_din_b;
        if (bus.ram_oe1) bus.ram_dout_a <= (mem[bus.ram_addra] | s1[bus.ram_addra]) & ~s0[bus.ram_addra];
        if (bus.ram_oe2) bus.ram_dout_b <= (mem[bus.ram_addrb] | s1[bus.ram_addrb]) & ~s0[bus.ram_addrb];
    end

    int viol, pat_bad, n_we1, n_we2, n_oe1, n_oe2;
    logic seen_w1;
    logic [AW-1:0] w1_addra, w1_addrb;

    always @(negedge clk) begin
        if (bus.ram_we1 && bus.ram_we2) viol++;
        if (bus.ram_we2 && bus.ram_addra == bus.ram_addrb) viol++;
        if (bus.ram_we1) begin
            n_we1++;
            if (bus.ram_din_a != bus.ram_addra[DW-1:0]) pat_bad++;
        end
        if (bus.ram_we2) begin
            n_we2++;
            if (bus.ram_din_b != ~bus.ram_addrb[DW-1:0]) pat_bad++;
            if (!seen_w1) begin
                seen_w1  = 1'b1;
                w1_addra = bus.ram_addra;
                w1_addrb = bus.ram_addrb;
            end
        end
        if (bus.ram_oe1) n_oe1++;
        if (bus.ram_oe2) n_oe2++;
    end

    function automatic logic [63:0] outs_vec();
        return {bus.busy, bus.done, bus.pass, bus.err_count, bus.fail_addr, bus.fail_phase,
                bus.ram_we1, bus.ram_oe1, bus.ram_we2, bus.ram_oe2,
                bus.ram_addra, bus.ram_addrb, bus.ram_din_a, bus.ram_din_b};
    endfunction

    function automatic logic [63:0] ram_side_vec();
        return {bus.ram_we1, bus.ram_oe1, bus.ram_we2, bus.ram_oe2,
                bus.ram_addra, bus.ram_addrb, bus.ram_din_a, bus.ram_din_b};
    endfunction

    // March algorithm in plain terms: every word written with P0 then read, then P1.
    task automatic model_run(output int e, output int fa, output int fp);
        logic [DW-1:0] pat, rd;
        e  = 0;
        fa = 0;
        fp = 0;
        for (int ph = 0; ph < 2; ph++) begin
            for (int a = 0; a < DEPTH; a++) begin
                pat = a[DW-1:0];
                if (ph == 1) pat = ~pat;
                rd = (pat | s1[a]) & ~s0[a];
                if (rd != pat) begin
                    if (e == 0) begin
                        fa = a;
                        fp = ph;
                    end
                    if (e < EMAX) e++;
                end
            end
        end
    endtask

    task automatic run_test(input string nm, input int stray_at, input int rst_at);
        int e_exp, fa_exp, fp_exp, done_k, busy_n;
        logic aborted;
        model_run(e_exp, fa_exp, fp_exp);
        done_k  = -1;
        busy_n  = 0;
        aborted = 1'b0;
        @(posedge clk);
        viol = 0; pat_bad = 0; n_we1 = 0; n_we2 = 0; n_oe1 = 0; n_oe2 = 0; seen_w1 = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 3 * TLEN; k++) begin
            @(negedge clk);
            bus.start = (k == stray_at - 1);
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                chk({nm, "_rst_outs"}, outs_vec(), 64'd0);
                aborted = 1'b1;
                break;
            end
            if (bus.done) begin
                done_k = k;
                break;
            end
            if (bus.busy) busy_n++;
        end
        bus.start = 1'b0;
        if (aborted) begin
            @(negedge clk);
            rst = 1'b0;
            repeat (5) @(negedge clk);
            chk({nm, "_idle_after_rst"}, {bus.busy, bus.done, bus.pass, bus.err_count}, 64'd0);
            return;
        end
        chk({nm, "_done_cycle"}, done_k, TLEN);
        chk({nm, "_busy_cycles"}, busy_n, TLEN);
        chk({nm, "_busy_at_done"}, bus.busy, 0);
        chk({nm, "_pass"}, bus.pass, (e_exp == 0));
        chk({nm, "_err_count"}, bus.err_count, e_exp);
        chk({nm, "_fail_addr"}, bus.fail_addr, fa_exp);
        chk({nm, "_fail_phase"}, bus.fail_phase, fp_exp);
        chk({nm, "_ram_idle"}, ram_side_vec(), 64'd0);
        chk({nm, "_port_viol"}, viol, 0);
        chk({nm, "_pattern"}, pat_bad, 0);
        chk({nm, "_enable_counts"}, {n_we1[15:0], n_oe2[15:0], n_we2[15:0], n_oe1[15:0]},
            {DEPTH[15:0], DEPTH[15:0], DEPTH[15:0], DEPTH[15:0]});
        chk({nm, "_w1_first_addr"}, {w1_addra, w1_addrb}, {AW'(1), AW'(0)});
        repeat (3) @(negedge clk);
        chk({nm, "_done_held"}, {bus.done, bus.busy}, 2'b10);
    endtask

    task automatic clear_faults();
        for (int a = 0; a < DEPTH; a++) begin
            s1[a] = '0;
            s0[a] = '0;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;
        clear_faults();
        repeat (3) @(negedge clk);
        chk("reset_outs", outs_vec(), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_outs", outs_vec(), 64'd0);

        run_test("clean_stray", 10, -1);

        s1[5] = 2'b01;
        run_test("addr5_bit0_sa1", -1, -1);

        clear_faults();
        for (int a = 0; a < DEPTH; a++) s0[a] = '1;
        run_test("all_sa0", -1, -1);

        run_test("abort", -1, 20);
        clear_faults();
        run_test("after_abort", -1, -1);

        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                s1[a] = ($urandom_range(0, 3) == 0) ? DW'($urandom) : '0;
                s0[a] = ($urandom_range(0, 3) == 0) ? DW'($urandom) : '0;
            end
            run_test($sformatf("rand%0d", r), -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
